// File: rtl/dmem_stream_reader.sv
// Streams LEN words from a combinational-read data memory onto a valid/ready output.
// Optional range check enabled by defining DMEM_STREAM_READER_BOUNDS_EN.
module dmem_stream_reader #(
  parameter int MEM_DEPTH = 129600,
  parameter int LEN_W     = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rd,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef DMEM_STREAM_READER_BOUNDS_EN
  localparam logic LP_BOUNDS_EN = 1'b1;
`else
  localparam logic LP_BOUNDS_EN = 1'b0;
`endif
  localparam logic [31:0] LP_MAX_ADDR = 32'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_load;
  logic             w_pop;
  logic             w_is_last;
  logic             w_oob;
  logic [LEN_W-1:0] w_idx_nxt;
  logic [31:0]      w_addr_nxt;
  logic [31:0]      w_ld_data;

  assign w_pop      = r_out_valid & out_ready;
  assign w_is_last  = (r_idx == (r_len - LEN_W'(1)));
  assign w_idx_nxt  = r_idx + LEN_W'(1);
  assign w_addr_nxt = r_base + 32'(w_idx_nxt);
  // Out-of-range words are zeroed only when the range check is built in.
  assign w_oob      = LP_BOUNDS_EN & (r_mem_addr > LP_MAX_ADDR);
  assign w_ld_data  = w_oob ? 32'h0000_0000 : mem_rd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, accept and load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (length != '0) begin
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!r_out_valid || out_ready) begin
          w_load = 1'b1;
          if (w_is_last) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_READ;
          end
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (w_pop) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transfer context and memory address; address advances only on a load so it holds during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= 32'h0000_0000;
      r_len      <= '0;
      r_idx      <= '0;
      r_mem_addr <= 32'h0000_0000;
    end else if (w_accept) begin
      r_base     <= base_addr;
      r_len      <= length;
      r_idx      <= '0;
      r_mem_addr <= base_addr;
    end else if (w_load) begin
      r_idx      <= w_idx_nxt;
      r_mem_addr <= w_addr_nxt;
    end
  end

  // Output register: load a new word, or retire the held one on a bare handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= 32'h0000_0000;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_ld_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_is_last;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Sticky range error, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_load && w_oob) begin
      r_err <= 1'b1;
    end
  end

  // Status flags registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_DRAIN);
      r_done <= (w_state_nxt == ST_FIN);
    end
  end

  assign mem_addr  = r_mem_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Randomized bench for dmem_stream_reader: a per-transfer expected-word queue built from
// address arithmetic, checked against every handshake. Honours DMEM_STREAM_READER_BOUNDS_EN.
module tb_dmem_stream_reader;

  localparam int MEM_DEPTH = 129600;
  localparam int LEN_W     = 18;
`ifdef DMEM_STREAM_READER_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_addr = 32'h0;
  logic [LEN_W-1:0] length = '0;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rd;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_stream_reader #(.MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  assign mem_rd = mem_word(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, "_out_data"}, out_data, 32'h0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_out_last"}, 32'(out_last), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,...
  task automatic run_xfer(input logic [31:0] b, input int len, input int mode, input bit mid_start);
    exp_t        e;
    logic        any_oob;
    logic        oob;
    logic [31:0] a;
    int          last_hs;
    int          done_cyc;
    bit          stall;
    logic [31:0] p_data;
    logic [31:0] p_addr;
    logic        p_last;
    logic        rdy;
    exp_q.delete();
    any_oob = 1'b0;
    for (int i = 0; i < len; i++) begin
      a       = b + 32'(i);
      oob     = BOUNDS && (a > 32'(MEM_DEPTH - 1));
      any_oob = any_oob | oob;
      e.data  = oob ? 32'h0 : mem_word(a);
      e.last  = (i == len - 1);
      e.err   = any_oob;
      exp_q.push_back(e);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    length    = LEN_W'(len);
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    length    = LEN_W'($urandom);

    if (len == 0) begin
      check_eq("zero_done", 32'(done), 32'h1);
      check_eq("zero_busy", 32'(busy), 32'h0);
      check_eq("zero_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      check_eq("zero_done_after", 32'(done), 32'h0);
      check_eq("zero_busy_after", 32'(busy), 32'h0);
      check_eq("zero_valid_after", 32'(out_valid), 32'h0);
      return;
    end

    check_eq("accept_addr", mem_addr, b);
    check_eq("accept_busy", 32'(busy), 32'h1);
    check_eq("accept_valid", 32'(out_valid), 32'h0);
    check_eq("accept_err", 32'(err), 32'h0);

    stall    = 1'b0;
    last_hs  = -1;
    done_cyc = -1;
    p_data   = 32'h0;
    p_addr   = 32'h0;
    p_last   = 1'b0;
    for (int cyc = 0; cyc < 8 * len + 20; cyc++) begin
      if (cyc == 1) check_eq("first_valid", 32'(out_valid), 32'h1);
      if (stall) begin
        check_eq("hold_valid", 32'(out_valid), 32'h1);
        check_eq("hold_data", out_data, p_data);
        check_eq("hold_last", 32'(out_last), 32'(p_last));
        check_eq("hold_addr", mem_addr, p_addr);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start     = mid_start && (cyc == 1 || cyc == 2);
      base_addr = b + 32'd777;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = ((cyc % 3) == 1);
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("word_data", out_data, e.data);
          check_eq("word_last", 32'(out_last), 32'(e.last));
          check_eq("word_err", 32'(err), 32'(e.err));
        end
        last_hs = cyc;
      end
      stall  = out_valid && !rdy;
      p_data = out_data;
      p_last = out_last;
      p_addr = mem_addr;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done_cyc >= 0), 32'h1);
    check_eq("done_timing", 32'(done_cyc), 32'(last_hs + 1));
    check_eq("words_left", 32'(exp_q.size()), 32'h0);
    check_eq("done_busy", 32'(busy), 32'h0);
    check_eq("done_valid", 32'(out_valid), 32'h0);
    check_eq("done_err", 32'(err), 32'(any_oob));
    @(negedge clk);
    check_eq("done_pulse_end", 32'(done), 32'h0);
    check_eq("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_xfer(32'd100, 4, 0, 1'b0);
    run_xfer(32'd100, 4, 2, 1'b0);
    run_xfer(32'd50, 0, 0, 1'b0);

    // Reset in the middle of a 10-word transfer, after two words
    @(negedge clk);
    start     = 1'b1;
    base_addr = 32'd300;
    length    = LEN_W'(10);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) begin
      @(negedge clk);
      check_eq("mid_reset_no_done", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    run_xfer(32'd0, 1, 0, 1'b0);

    run_xfer(32'd129598, 4, 0, 1'b0);
    run_xfer(32'd200, 6, 0, 1'b1);
    run_xfer(32'd200, 6, 1, 1'b1);
    run_xfer(32'hFFFF_FFFE, 4, 1, 1'b0);
    run_xfer(32'(MEM_DEPTH - 3), 5, 2, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_xfer(32'($urandom_range(0, 5000)), $urandom_range(1, 12), $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
